// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W producer records, raises stall on
// unresolved RAW / HI-LO hazards and picks forwarding sources for D and E operands.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_r_new,
    input  logic [1:0] d_t_new,
    input  logic [4:0] d_r_use1,
    input  logic [4:0] d_r_use2,
    input  logic [1:0] d_t_use1,
    input  logic [1:0] d_t_use2,
    input  logic       d_md_start,
    input  logic       d_md_is_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] fwd_d1_sel,
    output logic [1:0] fwd_d2_sel,
    output logic [1:0] fwd_e1_sel,
    output logic [1:0] fwd_e2_sel,
    output logic       md_busy
);

    logic [4:0] e_r_new_q, e_r_new_d, e_r_use1_q, e_r_use1_d, e_r_use2_q, e_r_use2_d;
    logic [1:0] e_t_new_q, e_t_new_d;
    logic       e_md_start_q, e_md_start_d, e_is_div_q, e_is_div_d;
    logic [4:0] m_r_new_q, m_r_new_d, w_r_new_q, w_r_new_d;
    logic [1:0] m_t_new_q, m_t_new_d, w_t_new_q, w_t_new_d;
    logic [3:0] cnt_q, cnt_d;
    logic       raw_stall_s;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        if (t == 2'd0) return 2'd0;
        else           return t - 2'd1;
    endfunction

    // Register 0 is hardwired; a match against it is never a dependency.
    function automatic logic raw_hazard(input logic [4:0] use_r, input logic [1:0] use_t,
                                        input logic [4:0] rn, input logic [1:0] tn);
        return (use_r != 5'd0) && (rn == use_r) && (tn > use_t);
    endfunction

    function automatic logic [1:0] fwd_d(input logic [4:0] use_r,
                                         input logic [4:0] er, input logic [1:0] et,
                                         input logic [4:0] mr, input logic [1:0] mt,
                                         input logic [4:0] wr, input logic [1:0] wt);
        if (use_r == 5'd0)    return 2'd0;
        else if (er == use_r) return (et == 2'd0) ? 2'd1 : 2'd0;
        else if (mr == use_r) return (mt == 2'd0) ? 2'd2 : 2'd0;
        else if (wr == use_r) return (wt == 2'd0) ? 2'd3 : 2'd0;
        else                  return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] use_r,
                                         input logic [4:0] mr, input logic [1:0] mt,
                                         input logic [4:0] wr, input logic [1:0] wt);
        if (use_r == 5'd0)    return 2'd0;
        else if (mr == use_r) return (mt == 2'd0) ? 2'd1 : 2'd0;
        else if (wr == use_r) return (wt == 2'd0) ? 2'd2 : 2'd0;
        else                  return 2'd0;
    endfunction

    assign md_busy = (cnt_q != 4'd0);

    // Hazard detection and forwarding selection.
    always_comb begin
        raw_stall_s = raw_hazard(d_r_use1, d_t_use1, e_r_new_q, e_t_new_q)
                    | raw_hazard(d_r_use1, d_t_use1, m_r_new_q, m_t_new_q)
                    | raw_hazard(d_r_use2, d_t_use2, e_r_new_q, e_t_new_q)
                    | raw_hazard(d_r_use2, d_t_use2, m_r_new_q, m_t_new_q);
        stall       = raw_stall_s | (d_md_use & (md_busy | e_md_start_q));
        fwd_d1_sel  = fwd_d(d_r_use1, e_r_new_q, e_t_new_q, m_r_new_q, m_t_new_q, w_r_new_q, w_t_new_q);
        fwd_d2_sel  = fwd_d(d_r_use2, e_r_new_q, e_t_new_q, m_r_new_q, m_t_new_q, w_r_new_q, w_t_new_q);
        fwd_e1_sel  = fwd_e(e_r_use1_q, m_r_new_q, m_t_new_q, w_r_new_q, w_t_new_q);
        fwd_e2_sel  = fwd_e(e_r_use2_q, m_r_new_q, m_t_new_q, w_r_new_q, w_t_new_q);
    end

    // Next-state for stage records and the mult/div busy counter.
    always_comb begin
        e_r_new_d    = d_r_new;
        e_t_new_d    = d_t_new;
        e_r_use1_d   = d_r_use1;
        e_r_use2_d   = d_r_use2;
        e_md_start_d = d_md_start;
        e_is_div_d   = d_md_is_div;
        if (stall) begin
            e_r_new_d    = 5'd0;
            e_t_new_d    = 2'd0;
            e_r_use1_d   = 5'd0;
            e_r_use2_d   = 5'd0;
            e_md_start_d = 1'b0;
            e_is_div_d   = 1'b0;
        end else begin
            e_md_start_d = d_md_start;
        end
        m_r_new_d = e_r_new_q;
        m_t_new_d = sat_dec(e_t_new_q);
        w_r_new_d = m_r_new_q;
        w_t_new_d = sat_dec(m_t_new_q);
        // Load only from idle so an in-flight operation is never restarted.
        if (e_md_start_q && (cnt_q == 4'd0)) cnt_d = e_is_div_q ? 4'd10 : 4'd5;
        else if (cnt_q != 4'd0)              cnt_d = cnt_q - 4'd1;
        else                                 cnt_d = cnt_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_r_new_q    <= 5'd0;
            e_t_new_q    <= 2'd0;
            e_r_use1_q   <= 5'd0;
            e_r_use2_q   <= 5'd0;
            e_md_start_q <= 1'b0;
            e_is_div_q   <= 1'b0;
            m_r_new_q    <= 5'd0;
            m_t_new_q    <= 2'd0;
            w_r_new_q    <= 5'd0;
            w_t_new_q    <= 2'd0;
            cnt_q        <= 4'd0;
        end else begin
            e_r_new_q    <= e_r_new_d;
            e_t_new_q    <= e_t_new_d;
            e_r_use1_q   <= e_r_use1_d;
            e_r_use2_q   <= e_r_use2_d;
            e_md_start_q <= e_md_start_d;
            e_is_div_q   <= e_is_div_d;
            m_r_new_q    <= m_r_new_d;
            m_t_new_q    <= m_t_new_d;
            w_r_new_q    <= w_r_new_d;
            w_t_new_q    <= w_t_new_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
